// File: rtl/data_mem_bytelane.sv
// Byte-addressed big-endian data memory for the MEM stage: byte/half/word
// access, registered 1-cycle loads, fault reporting and a reset-time INIT sweep.
module data_mem_bytelane #(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] out32,
    output logic        rvalid,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int NWORDS = 2 ** (ADDR_W - 2);
    localparam int PW     = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_run;
    logic [PW-1:0]     r_clr_ptr;
    logic [7:0]        r_mem [DEPTH];
    logic [31:0]       r_out32;
    logic              r_rvalid;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic              w_acc;
    logic              w_op;
    logic [2:0]        w_nbytes;
    logic [32:0]       w_last;
    logic              w_illegal;
    logic              w_range;
    logic              w_misal;
    logic [1:0]        w_code;
    logic              w_fault;
    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [31:0]       w_rd;
    logic [31:0]       w_ext;
    logic [ADDR_W-1:0] w_clr_base;
    logic [31:0]       w_clr_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? S_INIT : S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_clr_ptr == PW'(NWORDS - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign req_ready = w_run & ~rst;
    assign w_acc     = req_valid & req_ready;
    assign w_op      = memread | memwrite;

    always_comb begin
        case (size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    // 33-bit sum so addresses near 2**32 cannot wrap back into range
    assign w_last    = {1'b0, address} + 33'(w_nbytes) - 33'd1;
    assign w_illegal = (memread & memwrite) | ((size == 2'b11) & w_op);
    assign w_range   = w_op & (w_last > 33'(DEPTH - 1));
    assign w_misal   = w_op & (((size == 2'b01) & address[0])
                     | ((size == 2'b10) & (address[1:0] != 2'b00)));

    always_comb begin
        if (w_illegal) begin
            w_code = 2'b11;
        end else if (w_range) begin
            w_code = 2'b10;
        end else if (w_misal) begin
            w_code = 2'b01;
        end else begin
            w_code = 2'b00;
        end
    end

    assign w_fault = (w_code != 2'b00);
    assign w_a0    = address[ADDR_W-1:0];
    assign w_a1    = w_a0 + ADDR_W'(1);
    assign w_a2    = w_a0 + ADDR_W'(2);
    assign w_a3    = w_a0 + ADDR_W'(3);
    assign w_rd    = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

    always_comb begin
        w_ext = w_rd;
        case (size)
            2'b00:   w_ext = {{24{sign_ext & w_rd[31]}}, w_rd[31:24]};
            2'b01:   w_ext = {{16{sign_ext & w_rd[31]}}, w_rd[31:16]};
            default: w_ext = w_rd;
        endcase
    end

    assign w_clr_base = ADDR_W'({r_clr_ptr, 2'b00});

    always_comb begin
        if (32'(r_clr_ptr) == 32'd2) begin
            w_clr_word = 32'h0000_0008;
        end else if (32'(r_clr_ptr) == 32'd3) begin
            w_clr_word = 32'hFFFF_FFFF;
        end else begin
            w_clr_word = 32'h0000_0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_ptr  <= '0;
            r_out32    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            if (r_state == S_INIT) begin
                r_clr_ptr <= r_clr_ptr + PW'(1);
            end
            if (w_acc) begin
                if (w_fault) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_code;
                end else if (memread) begin
                    r_out32  <= w_ext;
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == S_INIT) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[w_clr_base + ADDR_W'(k)] <= w_clr_word[31-8*k -: 8];
            end
        end else if (w_acc && memwrite && !w_fault) begin
            case (size)
                2'b00: r_mem[w_a0] <= writeData[7:0];
                2'b01: begin
                    r_mem[w_a0] <= writeData[15:8];
                    r_mem[w_a1] <= writeData[7:0];
                end
                default: begin
                    r_mem[w_a0] <= writeData[31:24];
                    r_mem[w_a1] <= writeData[23:16];
                    r_mem[w_a2] <= writeData[15:8];
                    r_mem[w_a3] <= writeData[7:0];
                end
            endcase
        end
    end

    assign out32    = r_out32;
    assign rvalid   = r_rvalid;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Bench for data_mem_bytelane: directed scenarios with literal expectations,
// then random traffic checked every cycle against a byte-array reference model.
module tb_data_mem_bytelane;

    localparam int AW       = 8;
    localparam int DEPTH    = 2 ** AW;
    localparam int INIT_CYC = DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] out32;
    logic        rvalid;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl [DEPTH];
    int          cnt = 0;
    logic [31:0] exp_out32 = '0;
    logic        exp_rvalid = 1'b0;
    logic        exp_err = 1'b0;
    logic [1:0]  exp_code = 2'b00;
    bit          chk_en = 1'b0;

    data_mem_bytelane #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .memread(memread), .memwrite(memwrite), .size(size),
        .sign_ext(sign_ext), .address(address), .writeData(writeData),
        .out32(out32), .rvalid(rvalid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        mdl[11] = 8'h08;
        for (int i = 12; i < 16; i++) mdl[i] = 8'hFF;
    endtask

    task automatic model_step(input bit acc);
        int          nb;
        int          a;
        logic [63:0] last;
        logic [31:0] v;
        int          code;
        exp_rvalid = 1'b0;
        exp_err    = 1'b0;
        exp_code   = 2'b00;
        if (!acc || !(memread || memwrite)) return;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        last = {32'd0, address} + 64'(nb) - 64'd1;
        if ((memread && memwrite) || size == 2'd3) code = 3;
        else if (last > 64'(DEPTH - 1)) code = 2;
        else if ((address % nb) != 0) code = 1;
        else code = 0;
        if (code != 0) begin
            exp_err  = 1'b1;
            exp_code = 2'(code);
            return;
        end
        a = int'(address);
        if (memwrite) begin
            for (int i = 0; i < nb; i++)
                mdl[a+i] = 8'(writeData >> (8 * (nb - 1 - i)));
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(mdl[a+i]);
            if (sign_ext && nb < 4 && v[8*nb-1])
                v = v | (32'hFFFF_FFFF << (8 * nb));
            exp_out32  = v;
            exp_rvalid = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cnt        = 0;
            exp_out32  = '0;
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
            exp_code   = 2'b00;
            model_init();
        end else begin
            model_step(req_valid && cnt >= INIT_CYC);
            if (cnt < INIT_CYC) cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(cnt >= INIT_CYC && !rst));
            chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
            chk("err", 32'(err), 32'(exp_err));
            chk("out32", out32, exp_out32);
            if (exp_err) chk("err_code", 32'(err_code), 32'(exp_code));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [1:0] sz,
                       input bit se, input logic [31:0] a,
                       input logic [31:0] wd);
        req_valid = 1'b1;
        memread   = rd;
        memwrite  = wr;
        size      = sz;
        sign_ext  = se;
        address   = a;
        writeData = wd;
        step();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'(INIT_CYC));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        size = 2'd0;
        sign_ext = 1'b0;
        address = '0;
        writeData = '0;
        step();
        chk_en = 1'b1;
        chk("rst_out32", out32, 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;
        wait_ready("init_len");

        req(1, 0, 2'd2, 0, 32'h08, 0);
        chk("lw8_rvalid", 32'(rvalid), 32'h1);
        chk("lw8", out32, 32'h0000_0008);
        req(0, 1, 2'd2, 0, 32'h10, 32'hA1B2C3D4);
        req(1, 0, 2'd0, 0, 32'h11, 0);
        chk("lbu11", out32, 32'h0000_00B2);
        req(1, 0, 2'd1, 1, 32'h12, 0);
        chk("lh12", out32, 32'hFFFF_C3D4);
        req(0, 1, 2'd0, 0, 32'h13, 32'h0000_007F);
        req(1, 0, 2'd2, 0, 32'h10, 0);
        chk("fwd_lw10", out32, 32'hA1B2_C37F);

        req(1, 0, 2'd2, 0, 32'h06, 0);
        chk("mis_err", 32'(err), 32'h1);
        chk("mis_code", 32'(err_code), 32'h1);
        chk("mis_rvalid", 32'(rvalid), 32'h0);
        chk("mis_hold", out32, 32'hA1B2_C37F);
        req(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
        chk("oor_code", 32'(err_code), 32'h2);
        req(1, 1, 2'd2, 0, 32'h00, 0);
        chk("ill_code", 32'(err_code), 32'h3);
        req(1, 0, 2'd2, 0, 32'h00, 0);
        chk("unchanged0", out32, 32'h0);
        req(1, 0, 2'd1, 0, 32'hFF, 0);
        chk("lhff_code", 32'(err_code), 32'h2);
        req(1, 0, 2'd0, 1, 32'h0C, 0);
        chk("lb12", out32, 32'hFFFF_FFFF);
        idle();
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (29) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("reinit_len");
        req(1, 0, 2'd2, 0, 32'h08, 0);
        idle();
        rst = 1'b1;
        step();
        chk("rst_drop_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0;
        wait_ready("reinit2_len");

        for (int i = 0; i < 3000; i++) begin
            int k;
            int r;
            k = $urandom_range(0, 9);
            req_valid = ($urandom_range(0, 4) != 0);
            memread   = (k <= 4) || (k == 8);
            memwrite  = (k >= 5 && k <= 8);
            size      = ($urandom_range(0, 15) == 0) ? 2'd3
                                                     : 2'($urandom_range(0, 2));
            sign_ext  = 1'($urandom_range(0, 1));
            writeData = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6) address = $urandom_range(0, 63);
            else if (r < 8) address = $urandom_range(0, 255);
            else if (r == 8) address = $urandom_range(250, 262);
            else address = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) address[0] = 1'b0;
                if (size == 2'd2) address[1:0] = 2'b00;
            end
            step();
        end
        idle();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
